// File: rtl/serial_alu_seq_pkg.sv
// Shared definitions for the bit-serial add/subtract sequencer.
// State encoding and the decode that folds the unused code onto IDLE.
package serial_alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // 2'b11 is never entered; treat it as IDLE so a corrupted register recovers.
    function automatic state_t decode_state(input logic [1:0] raw);
        case (raw)
            2'b01:   decode_state = RUN;
            2'b10:   decode_state = DONE;
            default: decode_state = IDLE;
        endcase
    endfunction

endpackage

// File: rtl/FA.sv
// One-bit full-adder cell; the only arithmetic element in the serial ALU.
module FA (
    input  logic A,
    input  logic B,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = A ^ B ^ cin;
    assign cout = (A & B) | (cin & (A ^ B));

endmodule

// File: rtl/serial_alu_seq.sv
// WIDTH-bit add/subtract computed LSB first, one bit per clock, through a single
// shared full-adder cell, with start/busy/done handshake and registered flags.
module serial_alu_seq
    import serial_alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_MSB_IN = CNT_W'(WIDTH - 2);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    state_t           cur_state;

    logic [WIDTH-1:0] opa_reg;
    logic [WIDTH-1:0] opb_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt_reg;
    logic             carry_reg;
    logic             carry_msb_reg;

    logic [WIDTH-1:0] result_reg;
    logic             cout_reg;
    logic             overflow_reg;
    logic             zero_reg;

    logic             load;
    logic             step;
    logic             finish;
    logic             fa_sum;
    logic             fa_cout;

    FA u_fa (
        .A    (opa_reg[0]),
        .B    (opb_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign cur_state = decode_state(state_reg);
    assign acc_next  = {fa_sum, acc_reg[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = cur_state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (cur_state)
            IDLE: begin
                if (start && !abort) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        finish     = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is A + ~B + 1: invert B on load and seed the carry with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_reg       <= '0;
            opb_reg       <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            carry_reg     <= 1'b0;
            carry_msb_reg <= 1'b0;
        end else if (load) begin
            opa_reg   <= a;
            opb_reg   <= sub ? ~b : b;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            carry_reg <= sub;
        end else if (step) begin
            opa_reg   <= opa_reg >> 1;
            opb_reg   <= opb_reg >> 1;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_reg + 1'b1;
            carry_reg <= fa_cout;
            if (cnt_reg == CNT_MSB_IN) begin
                carry_msb_reg <= fa_cout;
            end
        end
    end

    // Visible result and flags change only on a completed operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_reg   <= '0;
            cout_reg     <= 1'b0;
            overflow_reg <= 1'b0;
            zero_reg     <= 1'b0;
        end else if (finish) begin
            result_reg   <= acc_next;
            cout_reg     <= fa_cout;
            overflow_reg <= carry_msb_reg ^ fa_cout;
            zero_reg     <= ~|acc_next;
        end
    end

    assign busy     = (cur_state != IDLE);
    assign done     = (cur_state == DONE);
    assign result   = result_reg;
    assign cout     = cout_reg;
    assign overflow = overflow_reg;
    assign zero     = zero_reg;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Randomized self-checking bench for serial_alu_seq at WIDTH=8 against a
// signed/unsigned arithmetic reference model.
module tb_serial_alu_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic             abort;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    int checks;
    int errors;

    logic [WIDTH-1:0] exp_res;
    logic             exp_cout;
    logic             exp_ov;
    logic             exp_zero;

    serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow),
        .zero     (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Reference: unsigned sum/difference for result and carry, true signed
    // arithmetic for overflow.
    task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                         output logic [WIDTH-1:0] r, output logic c, output logic v, output logic z);
        int full;
        int sx;
        int sy;
        int sr;
        if (s) full = int'(x) + ((1 << WIDTH) - 1 - int'(y)) + 1;
        else   full = int'(x) + int'(y);
        r  = full[WIDTH-1:0];
        c  = full[WIDTH];
        sx = x[WIDTH-1] ? int'(x) - (1 << WIDTH) : int'(x);
        sy = y[WIDTH-1] ? int'(y) - (1 << WIDTH) : int'(y);
        sr = s ? sx - sy : sx + sy;
        v  = (sr > (1 << (WIDTH - 1)) - 1) || (sr < -(1 << (WIDTH - 1)));
        z  = (r == '0);
    endtask

    task automatic check_held(input string tag);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        check({tag, "_ovf"}, 32'(overflow), 32'(exp_ov));
        check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    endtask

    // abort_at / jam_at: cycle after the start edge whose edge samples abort or
    // a second start (0 = never).
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input logic op_sub, input int abort_at, input int jam_at);
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic             z;
        model(op_a, op_b, op_sub, r, c, v, z);
        @(negedge clk);
        abort = 1'b0;
        a     = op_a;
        b     = op_b;
        sub   = op_sub;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int cyc = 1; cyc <= WIDTH; cyc++) begin
            @(negedge clk);
            abort = (cyc == abort_at);
            start = (cyc == jam_at);
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            sub   = 1'($urandom);
            @(posedge clk);
            #1;
            if (cyc == abort_at) begin
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check_held("abort_hold");
                $display("op %02h %s %02h aborted at cycle %0d", op_a, op_sub ? "-" : "+", op_b, cyc);
                return;
            end
            if (cyc < WIDTH) begin
                check("run_busy", 32'(busy), 32'd1);
                check("run_done", 32'(done), 32'd0);
            end
        end
        check("done_pulse", 32'(done), 32'd1);
        exp_res  = r;
        exp_cout = c;
        exp_ov   = v;
        exp_zero = z;
        check_held("op");
        $display("op %02h %s %02h -> %02h c=%0b v=%0b z=%0b (jam=%0d)",
                 op_a, op_sub ? "-" : "+", op_b, result, cout, overflow, zero, jam_at);
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        check_held("idle_hold");
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b1;
        abort    = 1'b0;
        sub      = 1'b0;
        a        = 8'h12;
        b        = 8'h34;
        exp_res  = '0;
        exp_cout = 1'b0;
        exp_ov   = 1'b0;
        exp_zero = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_held("rst");
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_busy", 32'(busy), 32'd0);
        $display("reset released");

        run_op(8'h3C, 8'h05, 1'b0, 0, 0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 0);
        run_op(8'h80, 8'h01, 1'b1, 0, 0);
        run_op(8'h55, 8'h55, 1'b1, 0, 0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 0);
        run_op(8'h10, 8'h20, 1'b0, 4, 0);
        run_op(8'h10, 8'h20, 1'b0, 0, 0);
        run_op(8'h21, 8'h42, 1'b0, 0, 3);
        run_op(8'h00, 8'h01, 1'b1, 0, WIDTH);

        // Asynchronous reset between edges in the middle of an operation.
        @(negedge clk);
        a     = 8'h99;
        b     = 8'h11;
        sub   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        exp_res  = '0;
        exp_cout = 1'b0;
        exp_ov   = 1'b0;
        exp_zero = 1'b0;
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        check_held("async_rst");
        $display("async reset mid-run");
        @(negedge clk);
        rst = 1'b0;
        run_op(8'hA5, 8'h5B, 1'b0, 0, 0);

        for (int i = 0; i < 60; i++) begin
            int ab;
            int jm;
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, WIDTH)) : 0;
            jm = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, WIDTH)) : 0;
            run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), ab, jm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
